// File: rtl/riscv_mem_pkg.sv
// Shared load/store definitions: funct3 codes, responder FSM states and
// the lane/alignment helpers used by the memory responder and the LSU checker.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

  // Byte lanes touched by an access of the given width at the given offset.
  function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: byte_enable = 4'b0001 << addr_lo;
      F3_H, F3_HU: byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        byte_enable = 4'b1111;
      default:     byte_enable = '0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: is_misaligned = addr_lo[0];
      F3_W:        is_misaligned = (addr_lo != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  // Unsigned widths exist only for loads; 011 and 11x are never legal.
  function automatic logic is_illegal_f3(input logic [2:0] funct3,
                                         input logic       we);
    case (funct3)
      F3_B, F3_H, F3_W: is_illegal_f3 = 1'b0;
      F3_BU, F3_HU:     is_illegal_f3 = we;
      default:          is_illegal_f3 = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_load_align.sv
// Selects the addressed byte/half out of a memory word and extends it
// according to the load's funct3.
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select then sign/zero extension.
  always_comb begin
    shifted = word >> {addr_lo, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
      F3_BU:   rdata = {24'b0, lane_b};
      F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
      F3_HU:   rdata = {16'b0, lane_h};
      F3_W:    rdata = word;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the LSU load/store port: one request at a time,
// WAIT_STATES extra cycles of latency, byte-lane stores, extended loads.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned     AW         = $clog2(DEPTH_WORDS);
  localparam longint unsigned BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd4;

  logic [31:0] mem [DEPTH_WORDS];

  mem_state_e  state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        enter_resp;

  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_f3;

  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_f3;
  logic        acc_err;
  logic [3:0]  acc_be;
  logic [AW-1:0] acc_idx;
  logic [31:0] acc_word, acc_rdata, st_word, wr_mask, new_word;

  // With no wait states the access happens on the accept edge itself, so the
  // live request feeds the datapath in IDLE; otherwise the latched copy does.
  always_comb begin
    if (state == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_f3    = req_funct3;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_f3    = lat_f3;
    end
  end

  // Error classification, store-lane merge and read word for the access.
  always_comb begin
    acc_be  = byte_enable(acc_f3, acc_addr[1:0]);
    acc_err = is_illegal_f3(acc_f3, acc_we)
            | is_misaligned(acc_f3, acc_addr[1:0])
            | ({32'b0, acc_addr} >= BYTE_LIMIT);
    acc_idx = acc_addr[AW+1:2];
    case (acc_f3[1:0])
      2'b00:   st_word = {4{acc_wdata[7:0]}};
      2'b01:   st_word = {2{acc_wdata[15:0]}};
      default: st_word = acc_wdata;
    endcase
    wr_mask  = {{8{acc_be[3]}}, {8{acc_be[2]}}, {8{acc_be[1]}}, {8{acc_be[0]}}};
    acc_word = mem[acc_idx];
    new_word = (acc_word & ~wr_mask) | (st_word & wr_mask);
  end

  load_align u_load_align (
    .word    (acc_word),
    .addr_lo (acc_addr[1:0]),
    .funct3  (acc_f3),
    .rdata   (acc_rdata)
  );

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    enter_resp   = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = '0;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'(WAIT_STATES - 1)) begin
          state_nxt    = S_RESP;
          wait_cnt_nxt = '0;
          enter_resp   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, request latch and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == S_IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_f3    <= req_funct3;
      end
      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? '0 : acc_rdata;
      end
    end
  end

  // Array write on the RESP-entry edge; reset suppresses it but never clears contents.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && !acc_err) mem[acc_idx] <= new_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_STATES 1, 0, 3) with a
// byte-level reference memory and a per-cycle response checker.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LIMIT = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [2:0]  req_funct3[3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES ((k == 0) ? 1 : ((k == 1) ? 0 : 3)),
      .INIT_FILE   ("")
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[k]),
      .req_ready  (req_ready[k]),
      .req_we     (req_we[k]),
      .req_addr   (req_addr[k]),
      .req_wdata  (req_wdata[k]),
      .req_funct3 (req_funct3[k]),
      .rsp_valid  (rsp_valid[k]),
      .rsp_ready  (rsp_ready[k]),
      .rsp_rdata  (rsp_rdata[k]),
      .rsp_err    (rsp_err[k])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h at t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Reference memory: plain bytes, little-endian.
  logic [7:0] mm [3][LIMIT];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } req_t;

  task automatic model_access(input int k, input req_t r, output logic err, output logic [31:0] rd);
    int unsigned sz;
    logic [31:0] v;
    sz  = (r.f3[1:0] == 2'b00) ? 1 : ((r.f3[1:0] == 2'b01) ? 2 : 4);
    err = (r.f3 == 3'b011) || (r.f3[2] && r.f3[1]) || (r.we && r.f3[2])
       || ((r.addr % sz) != 0) || (r.addr >= LIMIT);
    rd  = '0;
    if (!err) begin
      if (r.we) begin
        for (int unsigned i = 0; i < sz; i++) mm[k][r.addr + i] = 8'(r.wdata >> (8 * i));
      end else begin
        v = '0;
        for (int unsigned i = 0; i < sz; i++) v = v | (32'(mm[k][r.addr + i]) << (8 * i));
        if (!r.f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!r.f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endtask

  req_t        pend     [3];
  bit          pend_v   [3];
  bit          have_exp [3];
  logic        exp_err  [3];
  logic [31:0] exp_rd   [3];
  int          acc_cyc  [3];

  // Response checker: every cycle a response is visible it must match the model.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pend_v[k]   = 1'b0;
        have_exp[k] = 1'b0;
      end else begin
        if (rsp_valid[k]) begin
          if (!have_exp[k]) begin
            chk("rsp_has_request", k, 32'(pend_v[k]), 32'd1);
            if (pend_v[k]) begin
              model_access(k, pend[k], exp_err[k], exp_rd[k]);
              have_exp[k] = 1'b1;
              pend_v[k]   = 1'b0;
              chk("latency", k, 32'(cyc - acc_cyc[k]), 32'(1 + ws_of(k)));
            end
          end
          if (have_exp[k]) begin
            chk("rsp_err", k, 32'(rsp_err[k]), 32'(exp_err[k]));
            chk("rsp_rdata", k, rsp_rdata[k], exp_rd[k]);
            chk("req_ready_busy", k, 32'(req_ready[k]), 32'd0);
          end
          if (rsp_ready[k]) have_exp[k] = 1'b0;
        end
        if (req_valid[k] && req_ready[k]) begin
          chk("accept_while_busy", k, 32'(pend_v[k] || have_exp[k]), 32'd0);
          pend[k].we    = req_we[k];
          pend[k].addr  = req_addr[k];
          pend[k].wdata = req_wdata[k];
          pend[k].f3    = req_funct3[k];
          pend_v[k]     = 1'b1;
          acc_cyc[k]    = cyc;
        end
      end
    end
  end

  task automatic present(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
    req_we[k]     = we;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    req_funct3[k] = f3;
    req_valid[k]  = 1'b1;
  endtask

  task automatic wait_accept(input int k);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[k]) ok = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    chk("accept_timeout", k, 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input int k, output logic [31:0] rd, output logic err);
    bit ok = 1'b0;
    rd  = '0;
    err = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid[k]) begin
        ok  = 1'b1;
        rd  = rsp_rdata[k];
        err = rsp_err[k];
      end
    end
    @(posedge clk); #1;
    chk("rsp_timeout", k, 32'(ok), 32'd1);
  endtask

  task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rd, output logic err);
    present(k, we, addr, wdata, f3);
    wait_accept(k);
    wait_rsp(k, rd, err);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 1'b0;
      req_we[k]     = 1'b0;
      req_addr[k]   = '0;
      req_wdata[k]  = '0;
      req_funct3[k] = '0;
      rsp_ready[k]  = 1'b1;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset release
    @(negedge clk);
    chk("reset_req_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("reset_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("reset_rsp_rdata", 0, rsp_rdata[0], 32'd0);
    chk("reset_rsp_err", 0, 32'(rsp_err[0]), 32'd0);
    @(posedge clk); #1;

    // Basic word store/load
    do_req(0, 1'b1, 32'h0, 32'hDEADBEEF, 3'b010, rd, er);
    chk("sw_rdata_zero", 0, rd, 32'd0);
    do_req(0, 1'b0, 32'h0, 32'h0, 3'b010, rd, er);
    chk("lw0_lit", 0, rd, 32'hDEADBEEF);
    chk("lw0_err_lit", 0, 32'(er), 32'd0);

    // Byte / half lanes and extension
    do_req(0, 1'b1, 32'h4, 32'h11223344, 3'b010, rd, er);
    do_req(0, 1'b1, 32'h5, 32'hFFFFFF80, 3'b000, rd, er);
    do_req(0, 1'b0, 32'h5, 32'h0, 3'b000, rd, er);
    chk("lb5_lit", 0, rd, 32'hFFFFFF80);
    do_req(0, 1'b0, 32'h5, 32'h0, 3'b100, rd, er);
    chk("lbu5_lit", 0, rd, 32'h00000080);
    do_req(0, 1'b1, 32'h6, 32'hABCD1234, 3'b001, rd, er);
    do_req(0, 1'b0, 32'h4, 32'h0, 3'b010, rd, er);
    chk("lw4_lit", 0, rd, 32'h12348044);
    do_req(0, 1'b0, 32'h4, 32'h0, 3'b001, rd, er);
    chk("lh4_lit", 0, rd, 32'hFFFF8044);
    do_req(0, 1'b0, 32'h6, 32'h0, 3'b101, rd, er);
    chk("lhu6_lit", 0, rd, 32'h00001234);

    // Misaligned / illegal
    do_req(0, 1'b0, 32'h3, 32'h0, 3'b001, rd, er);
    chk("lh3_err_lit", 0, 32'(er), 32'd1);
    chk("lh3_rdata_lit", 0, rd, 32'd0);
    do_req(0, 1'b1, 32'h2, 32'hFFFFFFFF, 3'b010, rd, er);
    chk("sw2_err_lit", 0, 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h0, 32'h0, 3'b010, rd, er);
    chk("lw0_after_bad_sw", 0, rd, 32'hDEADBEEF);
    do_req(0, 1'b0, 32'h0, 32'h0, 3'b011, rd, er);
    chk("f3_011_err_lit", 0, 32'(er), 32'd1);
    do_req(0, 1'b1, 32'h4, 32'h0, 3'b100, rd, er);
    do_req(0, 1'b0, 32'h0, 32'h0, 3'b110, rd, er);

    // Range edges
    do_req(0, 1'b0, LIMIT, 32'h0, 3'b010, rd, er);
    chk("range_err_lit", 0, 32'(er), 32'd1);
    do_req(0, 1'b1, LIMIT - 4, 32'hA5A5A5A5, 3'b010, rd, er);
    do_req(0, 1'b0, LIMIT - 4, 32'h0, 3'b010, rd, er);
    chk("top_word_lit", 0, rd, 32'hA5A5A5A5);
    do_req(0, 1'b1, 32'h10, 32'h0BADC0DE, 3'b010, rd, er);
    do_req(0, 1'b1, 32'h14, 32'h55667788, 3'b010, rd, er);

    // Backpressure: response held for 5 cycles with a competing request
    rsp_ready[0] = 1'b0;
    present(0, 1'b0, 32'h4, 32'h0, 3'b010);
    wait_accept(0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (rsp_valid[0]) seen = 1'b1;
      end
      chk("bp_rsp_seen", 0, 32'(seen), 32'd1);
    end
    present(0, 1'b0, 32'h14, 32'h0, 3'b010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", 0, 32'(rsp_valid[0]), 32'd1);
      chk("bp_ready_low", 0, 32'(req_ready[0]), 32'd0);
      chk("bp_rdata_lit", 0, rsp_rdata[0], 32'h12348044);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_accept_next", 0, 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(0, rd, er);
    chk("bp_second_lit", 0, rd, 32'h55667788);

    // Reset during WAIT of a store
    do_req(0, 1'b0, 32'h14, 32'h0, 3'b010, rd, er);
    present(0, 1'b1, 32'h10, 32'hCAFEF00D, 3'b010);
    wait_accept(0);
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("rst_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_rdata", 0, rsp_rdata[0], 32'd0);
    chk("rst_rsp_err", 0, 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    chk("rst_store_dropped_lit", 0, rd, 32'h0BADC0DE);
    do_req(0, 1'b0, 32'h14, 32'h0, 3'b010, rd, er);
    chk("rst_neighbour_lit", 0, rd, 32'h55667788);
    do_req(0, 1'b0, 32'h0, 32'h0, 3'b010, rd, er);
    chk("rst_word0_lit", 0, rd, 32'hDEADBEEF);

    // Latency sweep: WAIT_STATES 0 and 3
    for (int k = 1; k < 3; k++) begin
      do_req(k, 1'b1, 32'h8, 32'h12345678, 3'b010, rd, er);
      do_req(k, 1'b0, 32'h8, 32'h0, 3'b010, rd, er);
      chk("ws_lw_lit", k, rd, 32'h12345678);
      do_req(k, 1'b0, 32'h9, 32'h0, 3'b000, rd, er);
      chk("ws_lb_lit", k, rd, 32'h00000056);
      do_req(k, 1'b0, LIMIT, 32'h0, 3'b010, rd, er);
      chk("ws_range_lit", k, 32'(er), 32'd1);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
